// File: rtl/preset_pkg.sv
// Shared types and constants for the preset flash sequencer: FSM states,
// preset word field layout and the erased-flash pattern.
package preset_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_LOAD_GAP,
        ST_IDLE,
        ST_WRITE,
        ST_WRITE_GAP
    } state_e;

    // Preset word layout: {status, data1, data2, bits_cnt}, one byte each.
    localparam int FIELD_W      = 8;
    localparam int STATUS_LSB   = 24;
    localparam int DATA1_LSB    = 16;
    localparam int DATA2_LSB    = 8;
    localparam int BITS_CNT_LSB = 0;

    localparam logic [31:0] ERASED_WORD = 32'hFFFF_FFFF;

    function automatic logic [FIELD_W-1:0] preset_field(input logic [31:0] word, input int lsb);
        return word[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/flash_access_retry.sv
// One flash access with retry: owns the strobe, the retry and timeout counters
// and the single strobe-low gap cycle between attempts.
module flash_access_retry #(
    parameter int MAX_RTY = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [23:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [23:0] spi_adr_o,
    output logic [31:0] spi_dat_o,
    output logic        spi_we_o,
    output logic        spi_stb_o,
    input  logic        spi_ack_i,
    input  logic        spi_rty_i,
    output logic        idle_o,
    output logic        done_o,
    output logic        retry_o,
    output logic        fail_o
);

    logic        stb_q, stb_d;
    logic        gap_q, gap_d;
    logic        we_q, we_d;
    logic [1:0]  rty_cnt_q, rty_cnt_d;
    logic [12:0] tmo_q, tmo_d;
    logic [23:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        refused;
    logic        last_try;

    assign idle_o    = !stb_q && !gap_q;
    assign spi_stb_o = stb_q;
    assign spi_we_o  = we_q;
    assign spi_adr_o = adr_q;
    assign spi_dat_o = dat_q;

    // NOTE: every signal gets its default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        stb_d     = stb_q;
        gap_d     = gap_q;
        we_d      = we_q;
        rty_cnt_d = rty_cnt_q;
        tmo_d     = tmo_q;
        adr_d     = adr_q;
        dat_d     = dat_q;

        // Ack has priority over a refusal or a timeout in the same cycle.
        refused  = stb_q && !spi_ack_i && (spi_rty_i || tmo_q == 13'(TIMEOUT - 1));
        last_try = rty_cnt_q == 2'(MAX_RTY - 1);
        done_o   = stb_q && spi_ack_i;
        retry_o  = refused && !last_try;
        fail_o   = refused && last_try;

        if (start_i && idle_o) begin
            stb_d     = 1'b1;
            we_d      = we_i;
            adr_d     = adr_i;
            dat_d     = dat_i;
            rty_cnt_d = '0;
            tmo_d     = '0;
        end else if (gap_q) begin
            gap_d = 1'b0;
            stb_d = 1'b1;
        end else if (stb_q) begin
            if (spi_ack_i) begin
                stb_d     = 1'b0;
                rty_cnt_d = '0;
                tmo_d     = '0;
            end else if (refused) begin
                stb_d = 1'b0;
                tmo_d = '0;
                if (last_try) begin
                    rty_cnt_d = '0;
                end else begin
                    rty_cnt_d = rty_cnt_q + 2'd1;
                    gap_d     = 1'b1;
                end
            end else begin
                tmo_d = tmo_q + 13'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            stb_q     <= 1'b0;
            gap_q     <= 1'b0;
            we_q      <= 1'b0;
            rty_cnt_q <= '0;
            tmo_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            stb_q     <= stb_d;
            gap_q     <= gap_d;
            we_q      <= we_d;
            rty_cnt_q <= rty_cnt_d;
            tmo_q     <= tmo_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

endmodule

// File: rtl/preset_flash_seq.sv
// Preset shadow store: loads all slots from SPI flash at boot, then writes
// back any slot saved by the user, lowest index first.
module preset_flash_seq #(
    parameter int          BUTTONS_CNT = 4,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          MAX_RTY     = 3,
    parameter int          TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst_i,
    output logic [23:0]            spi_adr_o,
    output logic [31:0]            spi_dat_o,
    output logic                   spi_we_o,
    output logic                   spi_stb_o,
    input  logic [31:0]            spi_dat_i,
    input  logic                   spi_ack_i,
    input  logic                   spi_rty_i,
    input  logic                   save_req_i,
    input  logic [1:0]             save_idx_i,
    input  logic [31:0]            save_dat_i,
    input  logic [1:0]             rd_idx_i,
    output logic [31:0]            rd_dat_o,
    output logic [BUTTONS_CNT-1:0] valid_o,
    output logic                   boot_done_o,
    output logic                   busy_o,
    output logic                   err_o
);

    import preset_pkg::*;

    localparam logic [1:0] LAST_SLOT = 2'(BUTTONS_CNT - 1);

    state_e                        state_q, state_d;
    logic [1:0]                    slot_q, slot_d;
    logic [BUTTONS_CNT-1:0][31:0]  shadow_q, shadow_d;
    logic [BUTTONS_CNT-1:0]        valid_q, valid_d;
    logic [BUTTONS_CNT-1:0]        dirty_q, dirty_d;
    logic                          boot_done_q, boot_done_d;
    logic                          err_q, err_d;
    logic [31:0]                   wr_dat_q, wr_dat_d;
    logic [1:0]                    first_dirty;
    logic                          acc_start, acc_idle, acc_done, acc_retry, acc_fail;

    flash_access_retry #(
        .MAX_RTY (MAX_RTY),
        .TIMEOUT (TIMEOUT)
    ) u_access (
        .clk       (clk),
        .rst_i     (rst_i),
        .start_i   (acc_start),
        .we_i      (state_q == ST_WRITE),
        .adr_i     (BASE_ADDR + {20'd0, slot_q, 2'b00}),
        .dat_i     (wr_dat_q),
        .spi_adr_o (spi_adr_o),
        .spi_dat_o (spi_dat_o),
        .spi_we_o  (spi_we_o),
        .spi_stb_o (spi_stb_o),
        .spi_ack_i (spi_ack_i),
        .spi_rty_i (spi_rty_i),
        .idle_o    (acc_idle),
        .done_o    (acc_done),
        .retry_o   (acc_retry),
        .fail_o    (acc_fail)
    );

    assign rd_dat_o    = shadow_q[rd_idx_i];
    assign valid_o     = valid_q;
    assign boot_done_o = boot_done_q;
    assign busy_o      = spi_stb_o;
    assign err_o       = err_q;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        boot_done_d = boot_done_q;
        err_d       = err_q;
        wr_dat_d    = wr_dat_q;
        acc_start   = 1'b0;

        first_dirty = '0;
        for (int i = BUTTONS_CNT - 1; i >= 0; i--) begin
            if (dirty_q[i]) first_dirty = 2'(i);
        end

        case (state_q)
            ST_LOAD: begin
                acc_start = acc_idle;
                if (acc_retry) begin
                    state_d = ST_LOAD_GAP;
                end else if (acc_done || acc_fail) begin
                    // A slot saved before its flash copy arrives keeps the saved value.
                    if (acc_done && !dirty_q[slot_q]) begin
                        shadow_d[slot_q] = spi_dat_i;
                        valid_d[slot_q]  = spi_dat_i != ERASED_WORD;
                    end
                    if (acc_fail) err_d = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        state_d     = ST_IDLE;
                        slot_d      = '0;
                        boot_done_d = 1'b1;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            ST_LOAD_GAP:  state_d = ST_LOAD;
            ST_IDLE: begin
                if (|dirty_q) begin
                    state_d  = ST_WRITE;
                    slot_d   = first_dirty;
                    wr_dat_d = shadow_q[first_dirty];
                end
            end
            ST_WRITE: begin
                acc_start = acc_idle;
                if (acc_retry) begin
                    state_d = ST_WRITE_GAP;
                end else if (acc_done || acc_fail) begin
                    if (acc_fail) err_d = 1'b1;
                    dirty_d[slot_q] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            ST_WRITE_GAP: state_d = ST_WRITE;
            default:      state_d = ST_LOAD;
        endcase

        // Applied last so a save overrides a same-cycle ack on the same slot.
        if (save_req_i) begin
            shadow_d[save_idx_i] = save_dat_i;
            valid_d[save_idx_i]  = 1'b1;
            dirty_d[save_idx_i]  = 1'b1;
        end
    end

    // NOTE: the shadow store is a handful of words that must read as zero after reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= ST_LOAD;
            slot_q      <= '0;
            shadow_q    <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            boot_done_q <= 1'b0;
            err_q       <= 1'b0;
            wr_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            boot_done_q <= boot_done_d;
            err_q       <= err_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

endmodule
